top_adder_reg: RTL and testbench

- Registered WIDTH-bit ripple-carry adder with carry-in and carry-out.
- Built from a chain of 1-bit full-adder cells; the result is captured in output registers.
- Serves as the top-level arithmetic block of the full_adder project and is verified exhaustively over all operand pairs and both carry-in values.

---
 rtl/adder_pkg.sv | 9 +
 rtl/full_adder_bit.sv | 13 +
 rtl/top_adder_reg.sv | 54 +++++
 tb/tb_top_adder_reg.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants and types for the registered ripple-carry adder.
// The result word packs the carry-out above the sum bits: {cout, sum}.
package adder_pkg;

    localparam int ADDER_WIDTH_DEFAULT = 4;

    typedef logic [ADDER_WIDTH_DEFAULT:0] adder_result_t;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full-adder cell; the top chains WIDTH of these into a ripple adder.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/top_adder_reg.sv
// Registered WIDTH-bit ripple-carry adder: {cout, sum} = a + b + cin, one cycle of latency.
// Sum and carry hold their last result while in_valid is low; out_valid flags new results.
module top_adder_reg
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);

    typedef logic [WIDTH:0] result_t;

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;
    result_t          result;

    assign carry[0] = cin;

    // Carry out of cell i feeds cell i+1; the last carry is the adder's carry-out.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_bit u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum_comb[i]),
            .co (carry[i+1])
        );
    end

    assign result = {carry[WIDTH], sum_comb};

    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= result[WIDTH-1:0];
                cout <= result[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_top_adder_reg.sv
// Scoreboard bench for top_adder_reg: a 4-bit instance checked every driven cycle
// and an 8-bit instance checked whenever it presents a valid result.
module tb_top_adder_reg;

    typedef struct {
        string      name;
        logic [3:0] sum;
        logic       cout;
        logic       valid;
    } exp4_t;

    typedef struct {
        string      name;
        logic [7:0] sum;
        logic       cout;
    } exp8_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       cin = 1'b0;
    logic [3:0] sum;
    logic       cout;
    logic       out_valid;

    logic       in_valid8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic [7:0] sum8;
    logic       cout8;
    logic       out_valid8;

    exp4_t q4[$];
    exp8_t q8[$];

    int total = 0;
    int bad   = 0;
    logic final_req = 1'b0;
    logic final_ack = 1'b0;

    always #5 clk = ~clk;

    top_adder_reg #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid)
    );

    top_adder_reg #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .sum       (sum8),
        .cout      (cout8),
        .out_valid (out_valid8)
    );

    // Drive one 4-bit cycle and queue what the outputs must show after the next edge.
    task automatic applyStimulus(input string name, input logic r, input logic v,
                                 input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                                 input logic [3:0] es, input logic ec, input logic ev);
        exp4_t e;
        @(negedge clk);
        rst      = r;
        in_valid = v;
        a        = ta;
        b        = tb;
        cin      = tc;
        e.name   = name;
        e.sum    = es;
        e.cout   = ec;
        e.valid  = ev;
        q4.push_back(e);
    endtask

    task automatic applyWide(input string name, input logic [7:0] ta, input logic [7:0] tb,
                             input logic tc, input logic [7:0] es, input logic ec);
        exp8_t e;
        @(negedge clk);
        in_valid8 = 1'b1;
        a8        = ta;
        b8        = tb;
        cin8      = tc;
        e.name    = name;
        e.sum     = es;
        e.cout    = ec;
        q8.push_back(e);
    endtask

    // Monitor: pops the scoreboards after each edge and compares against the DUT outputs.
    always @(posedge clk) begin
        exp4_t e;
        exp8_t w;
        #1;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            total++;
            if (sum !== e.sum || cout !== e.cout || out_valid !== e.valid) begin
                bad++;
                $display("[TB] FAIL %s: got sum=%h cout=%b valid=%b, want sum=%h cout=%b valid=%b",
                         e.name, sum, cout, out_valid, e.sum, e.cout, e.valid);
            end
        end
        if (out_valid8 !== 1'b0) begin
            total++;
            if (q8.size() == 0) begin
                bad++;
                $display("[TB] FAIL wide_unexpected: got out_valid8=%b sum8=%h, want no result",
                         out_valid8, sum8);
            end else begin
                w = q8.pop_front();
                if (out_valid8 !== 1'b1 || sum8 !== w.sum || cout8 !== w.cout) begin
                    bad++;
                    $display("[TB] FAIL %s: got sum=%h cout=%b valid=%b, want sum=%h cout=%b valid=1",
                             w.name, sum8, cout8, out_valid8, w.sum, w.cout);
                end
            end
        end
        if (final_req && !final_ack) begin
            total++;
            if (q4.size() != 0 || q8.size() != 0) begin
                bad++;
                $display("[TB] FAIL drain: got %0d/%0d pending results, want 0/0",
                         q4.size(), q8.size());
            end
            final_ack = 1'b1;
        end
    end

    task automatic checkOutput();
        final_req = 1'b1;
        for (int i = 0; i < 20 && !final_ack; i++) @(negedge clk);
        if (!final_ack) begin
            $display("[TB] FAIL final_check: got no ack, want ack within 20 cycles");
            $fatal(1, "[TB] monitor stalled");
        end
    endtask

    initial begin
        logic [4:0] r;
        logic [3:0] ea;
        logic [3:0] eb;
        logic [7:0] ab;

        // Reset held with live operands: everything must stay cleared.
        applyStimulus("reset_0", 1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0);
        applyStimulus("reset_1", 1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0);
        applyStimulus("reset_release", 1'b0, 1'b1, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b1);

        applyStimulus("ex_3p5", 1'b0, 1'b1, 4'd3, 4'd5, 1'b0, 4'd8, 1'b0, 1'b1);
        applyStimulus("ex_9p8c", 1'b0, 1'b1, 4'd9, 4'd8, 1'b1, 4'd2, 1'b1, 1'b1);
        applyStimulus("ripple_f0c", 1'b0, 1'b1, 4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1);
        applyStimulus("ripple_88", 1'b0, 1'b1, 4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1);
        applyStimulus("zero", 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1);

        // Every operand pair with both carry-ins, back to back.
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 256; i++) begin
                ab = 8'(i);
                ea = ab[7:4];
                eb = ab[3:0];
                r  = {1'b0, ea} + {1'b0, eb} + 5'(c);
                applyStimulus("exhaustive", 1'b0, 1'b1, ea, eb, 1'(c), r[3:0], r[4], 1'b1);
            end
        end

        applyStimulus("hold_load", 1'b0, 1'b1, 4'd2, 4'd3, 1'b0, 4'd5, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            applyStimulus("hold_idle", 1'b0, 1'b0, 4'd7, 4'd7, 1'b0, 4'd5, 1'b0, 1'b0);

        applyStimulus("stream_a", 1'b0, 1'b1, 4'd4, 4'd4, 1'b0, 4'd8, 1'b0, 1'b1);
        applyStimulus("stream_b", 1'b0, 1'b1, 4'd6, 4'd7, 1'b1, 4'hE, 1'b0, 1'b1);
        applyStimulus("mid_reset", 1'b1, 1'b1, 4'd1, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus("resume", 1'b0, 1'b1, 4'd1, 4'd1, 1'b0, 4'd2, 1'b0, 1'b1);
        applyStimulus("resume_2", 1'b0, 1'b1, 4'hC, 4'h5, 1'b1, 4'h2, 1'b1, 1'b1);
        applyStimulus("quiet", 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h2, 1'b1, 1'b0);

        applyWide("wide_ff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        applyWide("wide_7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
        applyWide("wide_ffffc", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        applyWide("wide_zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
